// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-miss, D-miss and write-through stores onto one multi-cycle memory port, streaming block fills back.
// Optional FILL_CRITICAL_WORD_FIRST_EN: issue order starts at the missed word and wraps within the block.
module cache_fill_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           icache_miss,
    input  logic [15:0]                    icache_miss_addr,
    input  logic                           dcache_miss,
    input  logic [15:0]                    dcache_miss_addr,
    input  logic                           dwrite_req,
    input  logic [15:0]                    dwrite_addr,
    input  logic [15:0]                    dwrite_data,
    output logic [15:0]                    mem_addr,
    output logic                           mem_enable,
    output logic                           mem_wr,
    output logic [15:0]                    mem_data_in,
    input  logic [15:0]                    mem_data_out,
    input  logic                           mem_data_valid,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           icache_fill_we,
    output logic                           dcache_fill_we,
    output logic                           icache_fill_done,
    output logic                           dcache_fill_done,
    output logic                           dwrite_ack,
    output logic                           busy
);
    localparam int WW = $clog2(BLOCK_WORDS);

    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_ISSUE, S_DRAIN, S_WRITE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      flush_cnt_q, flush_cnt_d;
    logic [WW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [WW-1:0]   ret_cnt_q, ret_cnt_d;
    logic [WW-1:0]   start_q, start_d;
    logic            owner_q, owner_d;
    logic [15:WW+1]  base_q, base_d;
    logic [15:0]     wr_addr_q, wr_addr_d;
    logic [15:0]     wr_data_q, wr_data_d;
    logic [15:0]     fill_data_q, fill_data_d;
    logic [WW-1:0]   fill_word_q, fill_word_d;
    logic            fill_we_q, fill_we_d;
    logic            fill_done_q, fill_done_d;
    logic [15:0]     sel_addr;
    logic            ret_valid;
    logic [WW-1:0]   issue_word;
    logic            unused_sel_bits;

    assign sel_addr        = icache_miss ? icache_miss_addr : dcache_miss_addr;
    assign unused_sel_bits = ^sel_addr[WW:0];
    assign ret_valid       = mem_data_valid && (state_q == S_ISSUE || state_q == S_DRAIN);
    assign issue_word      = start_q + issue_cnt_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        start_d     = start_q;
        owner_d     = owner_q;
        base_d      = base_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        fill_data_d = fill_data_q;
        fill_word_d = fill_word_q;
        fill_we_d   = 1'b0;
        fill_done_d = 1'b0;

        case (state_q)
            S_FLUSH: begin
                // Outstanding reads from before reset drain out during this window
                if (flush_cnt_q == 4'(MEM_LATENCY - 1)) begin
                    state_d     = S_IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            S_IDLE: begin
                if (icache_miss || dcache_miss) begin
                    state_d     = S_ISSUE;
                    owner_d     = !icache_miss;
                    base_d      = sel_addr[15:WW+1];
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
                    start_d     = sel_addr[WW:1];
`else
                    start_d     = '0;
`endif
                end else if (dwrite_req) begin
                    state_d   = S_WRITE;
                    wr_addr_d = dwrite_addr;
                    wr_data_d = dwrite_data;
                end
            end
            S_ISSUE: begin
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == WW'(BLOCK_WORDS - 1))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fill_done_q)
                    state_d = S_IDLE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_FLUSH;
        endcase

        if (ret_valid) begin
            fill_data_d = mem_data_out;
            fill_word_d = start_q + ret_cnt_q;
            fill_we_d   = 1'b1;
            fill_done_d = (ret_cnt_q == WW'(BLOCK_WORDS - 1));
            ret_cnt_d   = ret_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            start_q     <= '0;
            owner_q     <= 1'b0;
            base_q      <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fill_data_q <= '0;
            fill_word_q <= '0;
            fill_we_q   <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            start_q     <= start_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            fill_data_q <= fill_data_d;
            fill_word_q <= fill_word_d;
            fill_we_q   <= fill_we_d;
            fill_done_q <= fill_done_d;
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        if (state_q == S_ISSUE) begin
            mem_addr = {base_q, issue_word, 1'b0};
        end else if (state_q == S_WRITE) begin
            mem_addr    = wr_addr_q;
            mem_data_in = wr_data_q;
        end
    end

    assign mem_enable       = (state_q == S_ISSUE) || (state_q == S_WRITE);
    assign mem_wr           = (state_q == S_WRITE);
    assign dwrite_ack       = (state_q == S_WRITE);
    assign busy             = (state_q != S_IDLE);
    assign fill_data        = fill_data_q;
    assign fill_word        = fill_word_q;
    assign icache_fill_we   = fill_we_q && !owner_q;
    assign dcache_fill_we   = fill_we_q && owner_q;
    assign icache_fill_done = fill_done_q && !owner_q;
    assign dcache_fill_done = fill_done_q && owner_q;

endmodule
